fp_div: RTL and testbench

Sequential floating-point divider for the `tiny_nn_pkg::fp_t` format; the division counterpart to the combinational multiplier in the datapath. It computes `op_a / op_b` with a restoring mantissa divider that produces one quotient bit per cycle. Operands enter and results leave over valid/ready handshakes, so the block sits between a producer (operand sequencer) and a consumer (accumulator/writeback). There is no special-value handling; every encoding is treated as a normal number with a hidden one.

---
 rtl/fp_div.sv | 127 ++++++++++++
 tb/tb_fp_div.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/fp_div.sv
// Sequential floating-point divider for tiny_nn_pkg::fp_t: one restoring quotient
// bit per cycle, operands and result each exchanged over a valid/ready handshake.

package tiny_nn_pkg;
   localparam int FPMantWidth = 7;
   localparam int FPExpWidth  = 8;

   typedef struct packed {
      logic                   sign;
      logic [FPExpWidth-1:0]  exp;
      logic [FPMantWidth-1:0] mant;
   } fp_t;
endpackage

module fp_div
   import tiny_nn_pkg::*;
(
   input  logic       clk_i,
   input  logic       rst_i,
   input  fp_t        op_a_i,
   input  fp_t        op_b_i,
   input  logic       valid_i,
   output logic       ready_o,
   output fp_t        result_o,
   output logic       valid_o,
   input  logic       ready_i,
   output logic [1:0] state_o
);

   localparam int N  = FPMantWidth + 2;
   localparam int RW = FPMantWidth + 2;
   localparam int CW = $clog2(N);
   localparam logic [FPExpWidth-1:0] BIAS = FPExpWidth'(2 ** (FPExpWidth - 1));

   // Handshake: a transfer happens on a rising edge where valid and ready are both
   // high; valid is never withdrawn and the payload is held until that edge.
   typedef enum logic [1:0] {IDLE = 2'd0, DIVIDE = 2'd1, DONE = 2'd2} state_t;

   state_t                  state_q, state_d;
   logic                    sign_q;
   logic [FPExpWidth-1:0]   exp_q;
   logic [RW-1:0]           rem_q;
   logic [FPMantWidth:0]    div_q;
   logic [N-2:0]            quo_q;
   logic [CW-1:0]           cnt_q;
   fp_t                     result_q;

   logic                    step_ge;
   logic [RW-1:0]           rem_sub;
   logic [RW-1:0]           rem_next;
   logic [N-1:0]            quo_next;
   logic                    last_step;
   fp_t                     norm;

   always_comb begin
      state_d = state_q;
      ready_o = 1'b0;
      valid_o = 1'b0;
      unique case (state_q)
         IDLE: begin
            ready_o = 1'b1;
            if (valid_i) state_d = DIVIDE;
         end
         DIVIDE: if (last_step) state_d = DONE;
         DONE: begin
            valid_o = 1'b1;
            if (ready_i) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // The final quotient bit is folded into normalisation directly from quo_next,
   // so the stored quotient never needs its top bit.
   always_comb begin
      step_ge   = rem_q >= {1'b0, div_q};
      rem_sub   = rem_q - {1'b0, div_q};
      rem_next  = step_ge ? (rem_sub << 1) : (rem_q << 1);
      quo_next  = {quo_q, step_ge};
      last_step = cnt_q == CW'(N - 1);
      norm.sign = sign_q;
      if (quo_next[N-1]) begin
         norm.mant = quo_next[N-2:1];
         norm.exp  = exp_q;
      end else begin
         norm.mant = quo_next[N-3:0];
         norm.exp  = exp_q - FPExpWidth'(1);
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q  <= IDLE;
         sign_q   <= 1'b0;
         exp_q    <= '0;
         rem_q    <= '0;
         div_q    <= '0;
         quo_q    <= '0;
         cnt_q    <= '0;
         result_q <= '0;
      end else begin
         state_q <= state_d;
         unique case (state_q)
            IDLE: if (valid_i) begin
               sign_q <= op_a_i.sign ^ op_b_i.sign;
               // Only the low exponent bits survive, so wrap-around is computed here directly.
               exp_q  <= op_a_i.exp - op_b_i.exp + BIAS;
               rem_q  <= {1'b0, 1'b1, op_a_i.mant};
               div_q  <= {1'b1, op_b_i.mant};
               quo_q  <= '0;
               cnt_q  <= '0;
            end
            DIVIDE: begin
               rem_q <= rem_next;
               quo_q <= quo_next[N-2:0];
               cnt_q <= cnt_q + CW'(1);
               if (last_step) result_q <= norm;
            end
            default: ;
         endcase
      end
   end

   assign result_o = result_q;
   assign state_o  = state_q;

endmodule

// File: tb/tb_fp_div.sv
// Directed and random bench for fp_div: hand-computed quotients, latency,
// backpressure hold, reset abort, and an integer-division reference model.

module tb_fp_div;
   import tiny_nn_pkg::*;

   localparam int N  = FPMantWidth + 2;
   localparam int B  = 2 ** (FPExpWidth - 1);
   localparam int FW = $bits(fp_t);

   logic       clk = 1'b0;
   logic       rst_i;
   fp_t        op_a_i, op_b_i;
   logic       valid_i;
   logic       ready_o;
   fp_t        result_o;
   logic       valid_o;
   logic       ready_i;
   logic [1:0] state_o;

   int n_checks = 0;
   int n_fail   = 0;

   fp_div dut (
      .clk_i    (clk),
      .rst_i    (rst_i),
      .op_a_i   (op_a_i),
      .op_b_i   (op_b_i),
      .valid_i  (valid_i),
      .ready_o  (ready_o),
      .result_o (result_o),
      .valid_o  (valid_o),
      .ready_i  (ready_i),
      .state_o  (state_o)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
      n_checks++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, want);
      end
   endtask

   function automatic fp_t mk(input logic s, input int e, input int m);
      fp_t r;
      r.sign = s;
      r.exp  = FPExpWidth'(e);
      r.mant = FPMantWidth'(m);
      return r;
   endfunction

   // Reference: quotient = floor(1.ma * 2^(N-1) / 1.mb), value in (0.5, 2) scaled by 2^(N-1).
   function automatic fp_t model(input fp_t a, input fp_t b);
      int unsigned ma, mb, q;
      int e;
      fp_t r;
      ma = (1 << FPMantWidth) | int'(a.mant);
      mb = (1 << FPMantWidth) | int'(b.mant);
      q  = (ma << (N - 1)) / mb;
      e  = int'(a.exp) - int'(b.exp) + B;
      r.sign = a.sign ^ b.sign;
      if (q >= (1 << (N - 1))) begin
         r.mant = FPMantWidth'(q >> 1);
         r.exp  = FPExpWidth'(e);
      end else begin
         r.mant = FPMantWidth'(q);
         r.exp  = FPExpWidth'(e - 1);
      end
      return r;
   endfunction

   task automatic run_op(input fp_t a, input fp_t b, input fp_t want, input int hold, input string tag);
      int lat;
      @(negedge clk);
      check({tag, "_rdy_idle"}, 32'(ready_o), 1);
      op_a_i  = a;
      op_b_i  = b;
      valid_i = 1'b1;
      ready_i = (hold == 0);
      @(posedge clk);
      #1;
      valid_i = 1'b0;
      op_a_i  = fp_t'(FW'($urandom));
      op_b_i  = fp_t'(FW'($urandom));
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
         if (!valid_o) check({tag, "_busy_rdy"}, 32'(ready_o), 0);
      end while (!valid_o && lat < 4 * N);
      // First sample after the acceptance edge counts as 1; valid_o appears after edge k+N.
      check({tag, "_lat"}, 32'(lat), 32'(N + 1));
      check({tag, "_res"}, 32'(result_o), 32'(want));
      repeat (hold) begin
         @(negedge clk);
         check({tag, "_hold_vld"}, 32'(valid_o), 1);
         check({tag, "_hold_res"}, 32'(result_o), 32'(want));
         check({tag, "_hold_rdy"}, 32'(ready_o), 0);
      end
      ready_i = 1'b1;
      @(negedge clk);
      check({tag, "_post_vld"}, 32'(valid_o), 0);
      check({tag, "_post_rdy"}, 32'(ready_o), 1);
      check({tag, "_post_res"}, 32'(result_o), 32'(want));
   endtask

   initial begin
      fp_t a, b;
      rst_i   = 1'b1;
      valid_i = 1'b0;
      ready_i = 1'b1;
      op_a_i  = '0;
      op_b_i  = '0;
      repeat (3) @(posedge clk);
      #1 rst_i = 1'b0;
      @(negedge clk);
      check("rst_rdy",   32'(ready_o),  1);
      check("rst_vld",   32'(valid_o),  0);
      check("rst_res",   32'(result_o), 0);
      check("rst_state", 32'(state_o),  0);

      run_op(mk(0, B, 0),       mk(0, B, 0),        mk(0, B, 0),           0, "one_one");
      run_op(mk(0, B+1, 'h40),  mk(0, B+1, 0),      mk(0, B, 'h40),        0, "three_two");
      run_op(mk(0, B, 0),       mk(0, B, 'h40),     mk(0, B-1, 7'b0101010), 0, "one_1p5");
      run_op(mk(1, B+2, 0),     mk(0, B+1, 0),      mk(1, B+1, 0),         5, "neg_bp");
      run_op(mk(0, 0, 0),       mk(0, 255, 0),      mk(0, 129, 0),         0, "exp_wrap");
      run_op(mk(0, B, 'h7f),    mk(0, B, 0),        mk(0, B, 'h7f),        1, "max_mant");
      run_op(mk(0, B, 0),       mk(0, B, 'h7f),     mk(0, B-1, 0),         0, "min_quot");

      // Reset asserted at edge k+3 aborts the divide; valid_i during reset is ignored.
      @(negedge clk);
      op_a_i  = mk(0, B+3, 'h15);
      op_b_i  = mk(1, B-2, 'h33);
      valid_i = 1'b1;
      @(posedge clk);
      #1 valid_i = 1'b0;
      repeat (3) @(negedge clk);
      rst_i   = 1'b1;
      valid_i = 1'b1;
      @(posedge clk);
      #1;
      rst_i   = 1'b0;
      valid_i = 1'b0;
      @(negedge clk);
      check("abort_rdy",   32'(ready_o),  1);
      check("abort_vld",   32'(valid_o),  0);
      check("abort_res",   32'(result_o), 0);
      check("abort_state", 32'(state_o),  0);
      repeat (N + 3) begin
         @(negedge clk);
         check("abort_no_pulse", 32'(valid_o), 0);
      end
      run_op(mk(0, B, 0), mk(0, B, 0), mk(0, B, 0), 0, "after_abort");

      for (int i = 0; i < 1000; i++) begin
         a = fp_t'(FW'($urandom));
         b = fp_t'(FW'($urandom));
         run_op(a, b, model(a, b), ($urandom_range(0, 7) == 0) ? $urandom_range(1, 3) : 0, "rand");
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_checks, n_fail);
      $finish;
   end

endmodule
